// File: rtl/axi_mem_responder.sv
// axi_mem_responder
// AXI4 subordinate that terminates a 64-bit AXI4 memory port on an internal
// flop-based memory. It supports INCR bursts of full-width beats, with one
// outstanding burst per direction. The read and write paths are independent
// FSMs. IDs are echoed on B and R. A burst that touches any byte outside
// [BaseAddr, BaseAddr+MemBytes) completes all of its beats with SLVERR.
//
// Ports
//   clk_i, rst_i                    clock, asynchronous active-high reset
//   aw_* / w_* / b_*                write address, write data, write response
//   ar_* / r_*                      read address, read data
//   All outputs are 0 while rst_i is asserted.
module axi_mem_responder #(
    parameter int unsigned          AddrWidth = 64,
    parameter int unsigned          DataWidth = 64,
    parameter int unsigned          IdWidth   = 4,
    parameter int unsigned          MemBytes  = 4096,
    parameter logic [AddrWidth-1:0] BaseAddr  = 64'h8000_0000
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   aw_valid_i,
    output logic                   aw_ready_o,
    input  logic [IdWidth-1:0]     aw_id_i,
    input  logic [AddrWidth-1:0]   aw_addr_i,
    input  logic [7:0]             aw_len_i,
    input  logic                   w_valid_i,
    output logic                   w_ready_o,
    input  logic [DataWidth-1:0]   w_data_i,
    input  logic [DataWidth/8-1:0] w_strb_i,
    input  logic                   w_last_i,
    output logic                   b_valid_o,
    input  logic                   b_ready_i,
    output logic [IdWidth-1:0]     b_id_o,
    output logic [1:0]             b_resp_o,
    input  logic                   ar_valid_i,
    output logic                   ar_ready_o,
    input  logic [IdWidth-1:0]     ar_id_i,
    input  logic [AddrWidth-1:0]   ar_addr_i,
    input  logic [7:0]             ar_len_i,
    output logic                   r_valid_o,
    input  logic                   r_ready_i,
    output logic [IdWidth-1:0]     r_id_o,
    output logic [DataWidth-1:0]   r_data_o,
    output logic [1:0]             r_resp_o,
    output logic                   r_last_o
);

    localparam int unsigned BeatBytes = DataWidth / 8;
    localparam int unsigned OffW      = $clog2(BeatBytes);
    localparam int unsigned Words     = MemBytes / BeatBytes;
    localparam int unsigned WordAW    = $clog2(Words);
    localparam logic [AddrWidth:0] MemLo = {1'b0, BaseAddr};
    localparam logic [AddrWidth:0] MemHi = MemLo + (AddrWidth+1)'(MemBytes);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

    // The extra top bit keeps the end-of-burst sum from wrapping.
    function automatic logic range_err(input logic [AddrWidth-1:0] addr,
                                       input logic [7:0]           len);
        logic [AddrWidth:0] lo;
        logic [AddrWidth:0] hi;
        lo = {1'b0, addr} & ~(AddrWidth+1)'(BeatBytes - 1);
        hi = lo + (((AddrWidth+1)'(len) + (AddrWidth+1)'(1)) << OffW);
        return (lo < MemLo) || (hi > MemHi);
    endfunction

    // Only meaningful for in-range bursts; erroring bursts never touch memory.
    function automatic logic [WordAW-1:0] word_idx(input logic [AddrWidth-1:0] addr);
        return WordAW'((addr - BaseAddr) >> OffW);
    endfunction

    logic [DataWidth-1:0] r_mem [Words];

    // ---------------- write path ----------------
    w_state_e           r_w_state;
    w_state_e           w_w_next;
    logic [IdWidth-1:0] r_w_id;
    logic [WordAW-1:0]  r_w_idx;
    logic [7:0]         r_w_len;
    logic [7:0]         r_w_cnt;
    logic               r_w_err;
    logic               w_aw_hs;
    logic               w_w_hs;
    logic               w_w_beat_last;

    assign w_aw_hs       = aw_valid_i && aw_ready_o;
    assign w_w_hs        = w_valid_i && w_ready_o;
    assign w_w_beat_last = (r_w_cnt == r_w_len);
    assign b_id_o        = r_w_id;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_w_state <= W_IDLE;
        else       r_w_state <= w_w_next;
    end

    always_comb begin
        w_w_next   = r_w_state;
        aw_ready_o = 1'b0;
        w_ready_o  = 1'b0;
        b_valid_o  = 1'b0;
        b_resp_o   = '0;
        case (r_w_state)
            W_IDLE: begin
                aw_ready_o = !rst_i;
                if (aw_valid_i) w_w_next = W_DATA;
            end
            W_DATA: begin
                w_ready_o = 1'b1;
                if (w_valid_i && w_w_beat_last) w_w_next = W_RESP;
            end
            W_RESP: begin
                b_valid_o = 1'b1;
                b_resp_o  = {r_w_err, 1'b0};
                if (b_ready_i) w_w_next = W_IDLE;
            end
            default: w_w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_w_id  <= '0;
            r_w_idx <= '0;
            r_w_len <= '0;
            r_w_cnt <= '0;
            r_w_err <= 1'b0;
        end else if (w_aw_hs) begin
            r_w_id  <= aw_id_i;
            r_w_idx <= word_idx(aw_addr_i);
            r_w_len <= aw_len_i;
            r_w_cnt <= '0;
            r_w_err <= range_err(aw_addr_i, aw_len_i);
        end else if (w_w_hs) begin
            r_w_idx <= r_w_idx + WordAW'(1);
            r_w_cnt <= r_w_cnt + 8'd1;
            if (w_last_i != w_w_beat_last) r_w_err <= 1'b1;
        end
    end

    // Memory has no reset; a concurrent read sees the pre-write word.
    always_ff @(posedge clk_i) begin
        if (w_w_hs && !r_w_err) begin
            for (int unsigned i = 0; i < BeatBytes; i++) begin
                if (w_strb_i[i]) r_mem[r_w_idx][8*i +: 8] <= w_data_i[8*i +: 8];
            end
        end
    end

    // ---------------- read path ----------------
    r_state_e           r_r_state;
    r_state_e           w_r_next;
    logic [IdWidth-1:0] r_r_id;
    logic [WordAW-1:0]  r_r_idx;
    logic [7:0]         r_r_len;
    logic [7:0]         r_r_cnt;
    logic               r_r_err;
    logic               w_ar_hs;
    logic               w_r_hs;

    assign w_ar_hs  = ar_valid_i && ar_ready_o;
    assign w_r_hs   = r_valid_o && r_ready_i;
    assign r_id_o   = r_r_id;
    assign r_data_o = (r_r_state == R_DATA && !r_r_err) ? r_mem[r_r_idx] : '0;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) r_r_state <= R_IDLE;
        else       r_r_state <= w_r_next;
    end

    always_comb begin
        w_r_next   = r_r_state;
        ar_ready_o = 1'b0;
        r_valid_o  = 1'b0;
        r_resp_o   = '0;
        r_last_o   = 1'b0;
        case (r_r_state)
            R_IDLE: begin
                ar_ready_o = !rst_i;
                if (ar_valid_i) w_r_next = R_DATA;
            end
            R_DATA: begin
                r_valid_o = 1'b1;
                r_resp_o  = {r_r_err, 1'b0};
                r_last_o  = (r_r_cnt == r_r_len);
                if (r_ready_i && r_r_cnt == r_r_len) w_r_next = R_IDLE;
            end
            default: w_r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_r_id  <= '0;
            r_r_idx <= '0;
            r_r_len <= '0;
            r_r_cnt <= '0;
            r_r_err <= 1'b0;
        end else if (w_ar_hs) begin
            r_r_id  <= ar_id_i;
            r_r_idx <= word_idx(ar_addr_i);
            r_r_len <= ar_len_i;
            r_r_cnt <= '0;
            r_r_err <= range_err(ar_addr_i, ar_len_i);
        end else if (w_r_hs) begin
            r_r_idx <= r_r_idx + WordAW'(1);
            r_r_cnt <= r_r_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_axi_mem_responder.sv
// tb_axi_mem_responder
// Directed bench for axi_mem_responder with default parameters. Inputs are
// driven 1 time unit after the rising edge, and outputs are sampled at that
// same point, before the next edge.
module tb_axi_mem_responder;

    localparam logic [63:0] Base = 64'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        aw_valid_i, aw_ready_o;
    logic [3:0]  aw_id_i;
    logic [63:0] aw_addr_i;
    logic [7:0]  aw_len_i;
    logic        w_valid_i, w_ready_o;
    logic [63:0] w_data_i;
    logic [7:0]  w_strb_i;
    logic        w_last_i;
    logic        b_valid_o, b_ready_i;
    logic [3:0]  b_id_o;
    logic [1:0]  b_resp_o;
    logic        ar_valid_i, ar_ready_o;
    logic [3:0]  ar_id_i;
    logic [63:0] ar_addr_i;
    logic [7:0]  ar_len_i;
    logic        r_valid_o, r_ready_i;
    logic [3:0]  r_id_o;
    logic [63:0] r_data_o;
    logic [1:0]  r_resp_o;
    logic        r_last_o;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    always #5 clk = ~clk;

    axi_mem_responder #(
        .AddrWidth (64),
        .DataWidth (64),
        .IdWidth   (4),
        .MemBytes  (4096),
        .BaseAddr  (Base)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .aw_valid_i (aw_valid_i),
        .aw_ready_o (aw_ready_o),
        .aw_id_i    (aw_id_i),
        .aw_addr_i  (aw_addr_i),
        .aw_len_i   (aw_len_i),
        .w_valid_i  (w_valid_i),
        .w_ready_o  (w_ready_o),
        .w_data_i   (w_data_i),
        .w_strb_i   (w_strb_i),
        .w_last_i   (w_last_i),
        .b_valid_o  (b_valid_o),
        .b_ready_i  (b_ready_i),
        .b_id_o     (b_id_o),
        .b_resp_o   (b_resp_o),
        .ar_valid_i (ar_valid_i),
        .ar_ready_o (ar_ready_o),
        .ar_id_i    (ar_id_i),
        .ar_addr_i  (ar_addr_i),
        .ar_len_i   (ar_len_i),
        .r_valid_o  (r_valid_o),
        .r_ready_i  (r_ready_i),
        .r_id_o     (r_id_o),
        .r_data_o   (r_data_o),
        .r_resp_o   (r_resp_o),
        .r_last_o   (r_last_o)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic aw_send(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len);
        int k = 0;
        aw_id_i = id; aw_addr_i = addr; aw_len_i = len; aw_valid_i = 1'b1;
        while (!aw_ready_o && k < 20) begin tick(); k++; end
        check("aw_ready", aw_ready_o, 1);
        tick();
        aw_valid_i = 1'b0;
    endtask

    task automatic w_send(input logic [63:0] data, input logic [7:0] strb, input logic last);
        int k = 0;
        w_data_i = data; w_strb_i = strb; w_last_i = last; w_valid_i = 1'b1;
        while (!w_ready_o && k < 20) begin tick(); k++; end
        check("w_ready", w_ready_o, 1);
        tick();
        w_valid_i = 1'b0;
    endtask

    task automatic b_recv(input string tag, input logic [3:0] id, input logic [1:0] resp);
        int k = 0;
        b_ready_i = 1'b1;
        while (!b_valid_o && k < 20) begin tick(); k++; end
        check({tag, "_bvalid"}, b_valid_o, 1);
        check({tag, "_bid"}, b_id_o, id);
        check({tag, "_bresp"}, b_resp_o, resp);
        tick();
        b_ready_i = 1'b0;
    endtask

    task automatic ar_send(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len);
        int k = 0;
        ar_id_i = id; ar_addr_i = addr; ar_len_i = len; ar_valid_i = 1'b1;
        while (!ar_ready_o && k < 20) begin tick(); k++; end
        check("ar_ready", ar_ready_o, 1);
        tick();
        ar_valid_i = 1'b0;
        check("r_valid_t1", r_valid_o, 1);
    endtask

    task automatic r_recv(input string tag, input logic [3:0] id, input logic [63:0] data,
                          input logic [1:0] resp, input logic last);
        int k = 0;
        r_ready_i = 1'b1;
        while (!r_valid_o && k < 20) begin tick(); k++; end
        check({tag, "_rvalid"}, r_valid_o, 1);
        check({tag, "_rid"}, r_id_o, id);
        check({tag, "_rdata"}, r_data_o, data);
        check({tag, "_rresp"}, r_resp_o, resp);
        check({tag, "_rlast"}, r_last_o, last);
        tick();
        r_ready_i = 1'b0;
    endtask

    initial begin
        rst_i = 1'b1;
        aw_valid_i = 0; aw_id_i = '0; aw_addr_i = '0; aw_len_i = '0;
        w_valid_i = 0; w_data_i = '0; w_strb_i = '0; w_last_i = 0;
        b_ready_i = 0;
        ar_valid_i = 0; ar_id_i = '0; ar_addr_i = '0; ar_len_i = '0;
        r_ready_i = 0;

        // Reset state
        repeat (2) tick();
        check("rst_aw_ready", aw_ready_o, 0);
        check("rst_ar_ready", ar_ready_o, 0);
        check("rst_b_valid", b_valid_o, 0);
        check("rst_r_valid", r_valid_o, 0);
        check("rst_r_data", r_data_o, 0);
        rst_i = 1'b0;
        #1;
        check("idle_aw_ready", aw_ready_o, 1);
        check("idle_ar_ready", ar_ready_o, 1);

        // Single-beat write then read
        aw_send(4'd3, Base + 64'h10, 8'd0);
        check("w_ready_t1", w_ready_o, 1);
        w_send(64'h1122334455667788, 8'hFF, 1'b1);
        check("b_valid_t1", b_valid_o, 1);
        b_recv("single", 4'd3, 2'b00);
        ar_send(4'd3, Base + 64'h10, 8'd0);
        r_recv("single", 4'd3, 64'h1122334455667788, 2'b00, 1'b1);

        // Partial strobe over the same word
        aw_send(4'd1, Base + 64'h10, 8'd0);
        w_send(64'hFFFFFFFFFFFFFFFF, 8'h0F, 1'b1);
        b_recv("strb", 4'd1, 2'b00);
        ar_send(4'd2, Base + 64'h10, 8'd0);
        r_recv("strb", 4'd2, 64'h11223344FFFFFFFF, 2'b00, 1'b1);

        // 4-beat burst, read back with r_ready toggling every cycle
        aw_send(4'd5, Base + 64'h100, 8'd3);
        for (int i = 1; i <= 4; i++) w_send(64'(i), 8'hFF, i == 4);
        b_recv("burst", 4'd5, 2'b00);
        ar_send(4'd6, Base + 64'h100, 8'd3);
        for (int i = 1; i <= 4; i++) begin
            r_ready_i = 1'b0;
            check("burst_stall_valid", r_valid_o, 1);
            check("burst_stall_data", r_data_o, 64'(i));
            check("burst_stall_last", r_last_o, i == 4);
            tick();
            r_ready_i = 1'b1;
            check("burst_held_data", r_data_o, 64'(i));
            check("burst_held_id", r_id_o, 6);
            check("burst_held_last", r_last_o, i == 4);
            tick();
        end
        r_ready_i = 1'b0;
        check("burst_end_rvalid", r_valid_o, 0);
        check("burst_end_ar_ready", ar_ready_o, 1);

        // Top word of memory: last in-range beat is accepted
        aw_send(4'd4, Base + 64'hFF8, 8'd0);
        w_send(64'hCAFEF00DDEADBEEF, 8'hFF, 1'b1);
        b_recv("top", 4'd4, 2'b00);

        // Out of range: second beat crosses the end
        ar_send(4'd7, Base + 64'hFF8, 8'd1);
        r_recv("oor_r0", 4'd7, 64'h0, 2'b10, 1'b0);
        r_recv("oor_r1", 4'd7, 64'h0, 2'b10, 1'b1);
        check("oor_r_done", r_valid_o, 0);
        aw_send(4'd8, Base + 64'hFF8, 8'd1);
        w_send(64'hAAAAAAAAAAAAAAAA, 8'hFF, 1'b0);
        w_send(64'hBBBBBBBBBBBBBBBB, 8'hFF, 1'b1);
        check("oor_b_valid_t1", b_valid_o, 1);
        b_recv("oor", 4'd8, 2'b10);
        ar_send(4'd13, Base + 64'hFF8, 8'd0);
        r_recv("oor_kept", 4'd13, 64'hCAFEF00DDEADBEEF, 2'b00, 1'b1);

        // Below the base address
        ar_send(4'd14, Base - 64'h8, 8'd0);
        r_recv("below", 4'd14, 64'h0, 2'b10, 1'b1);

        // Concurrent R and W beat to the same word
        aw_send(4'd4, Base + 64'h200, 8'd0);
        w_send(64'h1111, 8'hFF, 1'b1);
        b_recv("conc_pre", 4'd4, 2'b00);
        ar_id_i = 4'd9;  ar_addr_i = Base + 64'h200; ar_len_i = 8'd0; ar_valid_i = 1'b1;
        aw_id_i = 4'd10; aw_addr_i = Base + 64'h200; aw_len_i = 8'd0; aw_valid_i = 1'b1;
        tick();
        ar_valid_i = 1'b0; aw_valid_i = 1'b0;
        w_data_i = 64'h2222; w_strb_i = 8'hFF; w_last_i = 1'b1; w_valid_i = 1'b1;
        r_ready_i = 1'b1;
        check("conc_r_valid", r_valid_o, 1);
        check("conc_w_ready", w_ready_o, 1);
        check("conc_old_data", r_data_o, 64'h1111);
        check("conc_r_last", r_last_o, 1);
        tick();
        w_valid_i = 1'b0; r_ready_i = 1'b0;
        check("conc_r_done", r_valid_o, 0);
        check("conc_b_valid", b_valid_o, 1);
        b_recv("conc", 4'd10, 2'b00);
        ar_send(4'd11, Base + 64'h200, 8'd0);
        r_recv("conc_new", 4'd11, 64'h2222, 2'b00, 1'b1);

        // Reset in the middle of an 8-beat read
        ar_send(4'd12, Base + 64'h100, 8'd7);
        r_ready_i = 1'b1;
        check("mid_beat1", r_data_o, 64'h1);
        tick();
        check("mid_beat2", r_data_o, 64'h2);
        tick();
        rst_i = 1'b1;
        #1;
        check("mid_rst_rvalid", r_valid_o, 0);
        check("mid_rst_ar_ready", ar_ready_o, 0);
        check("mid_rst_rdata", r_data_o, 0);
        check("mid_rst_rid", r_id_o, 0);
        tick();
        rst_i = 1'b0;
        #1;
        check("mid_rel_ar_ready", ar_ready_o, 1);
        check("mid_rel_aw_ready", aw_ready_o, 1);
        for (int i = 0; i < 4; i++) begin
            check("mid_no_residual", r_valid_o, 0);
            tick();
        end
        r_ready_i = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/axi_mem_responder.md
# axi_mem_responder

AXI4 subordinate that terminates the core's 64-bit AXI4 memory port on an internal flop-based memory. It accepts the INCR read and write bursts the core issues: single beats for uncached and write-through traffic, and multi-beat reads for 128-bit I$/D$ line refills. It returns B and R responses with the request ID echoed. It serves as the simulation and small-FPGA memory model on the far side of the core's AXI master.

## Interface
- AddrWidth, 64, AXI address width
- DataWidth, 64, AXI data width; beat size is fixed at DataWidth/8 bytes
- IdWidth, 4, AXI ID width
- MemBytes, 4096, memory size in bytes; must be a power of two and a multiple of DataWidth/8
- BaseAddr, 64'h8000_0000, byte address of memory word 0
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- aw_valid_i / aw_ready_o  in/out  1  AW handshake
- aw_id_i  in  IdWidth  write ID
- aw_addr_i  in  AddrWidth  write start byte address
- aw_len_i  in  8  write beats minus 1
- w_valid_i / w_ready_o  in/out  1  W handshake
- w_data_i  in  DataWidth  write data
- w_strb_i  in  DataWidth/8  byte enables
- w_last_i  in  1  last write beat
- b_valid_o / b_ready_i  out/in  1  B handshake
- b_id_o  out  IdWidth  echoed AW ID
- b_resp_o  out  2  00 OKAY, 10 SLVERR
- ar_valid_i / ar_ready_o  in/out  1  AR handshake
- ar_id_i  in  IdWidth  read ID
- ar_addr_i  in  AddrWidth  read start byte address
- ar_len_i  in  8  read beats minus 1
- r_valid_o / r_ready_i  out/in  1  R handshake
- r_id_o  out  IdWidth  echoed AR ID
- r_data_o  out  DataWidth  read data
- r_resp_o  out  2  00 OKAY, 10 SLVERR
- r_last_o  out  1  last read beat

## Operation
- The read and write paths are two independent FSMs. Each path has at most one outstanding burst.
- Burst type is always INCR and size is always full width. The low log2(DataWidth/8) address bits are ignored.
- Write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE:
  - W_IDLE: aw_ready_o=1. On the AW handshake, latch ID, word address and len. Compute err.
  - W_DATA: w_ready_o=1. Each W handshake writes the strobed bytes (only when err=0) and increments the word address.
  - W_DATA exits after beat len+1. If w_last_i disagrees with the beat count on any beat, err is set; data already written is kept.
  - W_RESP: b_valid_o=1 and b_resp_o={err,1'b0} until b_ready_i.
- Read FSM R_IDLE -> R_DATA -> R_IDLE:
  - R_IDLE: ar_ready_o=1. On the AR handshake, latch ID, address, len and err.
  - R_DATA: r_valid_o=1. r_data_o is the combinational read of the current word, or 0 when err=1.
  - r_last_o=1 when the beat count equals len. Each R handshake advances one beat. After the last beat the FSM returns to R_IDLE.
- err is set when any beat of the burst falls outside [BaseAddr, BaseAddr+MemBytes). The range compare is done in AddrWidth+1 bits so that no wrap-around occurs. An erroring burst still completes all len+1 beats with SLVERR; no memory write occurs.
- Simultaneous R beat and W beat to the same word: R returns the old data. The write is visible from the next cycle.
- Memory contents are not reset.

## Timing
- While rst_i is asserted, all outputs are 0. This includes ready signals, valid signals, IDs, data and resp.
- After reset release, both FSMs are idle: aw_ready_o=1, ar_ready_o=1. A reset mid-burst abandons the transaction; no B or R is issued.
- AW handshake at cycle t: w_ready_o=1 from t+1. The last W handshake at t: b_valid_o=1 at t+1.
- AR handshake at t: first r_valid_o at t+1.
- Throughput is 1 beat per cycle on W and R. Back-to-back bursts leave a 1-cycle idle gap per path (the ready cycle).
- While valid=1 and ready=0, r_data_o, r_id_o, r_resp_o, r_last_o, b_id_o and b_resp_o remain stable.

## Test plan
- Single-beat write then read:
  - Stimulus: AW id=3, addr=BaseAddr+0x10, len=0; W 0x1122334455667788, strb FF, last=1.
  - Response: B id=3 OKAY one cycle after the W handshake. AR to the same address returns R id=3, data 0x1122334455667788, OKAY, last=1.
- Partial strobe: write 0xFFFFFFFFFFFFFFFF with strb 0F over the previous word -> read returns 0x11223344FFFFFFFF.
- Burst with stalls:
  - Stimulus: write len=3, words 1..4; then read len=3 with r_ready_i toggling every cycle.
  - Response: beats 1,2,3,4 in order, outputs held stable while stalled, r_last_o only on the 4th beat.
- Out of range:
  - Stimulus: AR addr=BaseAddr+MemBytes-8, len=1; then AW to the same address with len=1.
  - Response: the read gives 2 beats, SLVERR, data 0. The write gives B SLVERR, and a subsequent read shows the last in-range word unchanged.
- Concurrency: R beat and W beat to the same word in the same cycle -> R carries the old value; a read one cycle later carries the new value; both B and R complete.
- Reset mid-burst:
  - Stimulus: assert rst_i after beat 2 of a len=7 read.
  - Response: r_valid_o=0 immediately (asynchronous). After release, ar_ready_o=1 and no residual R beats appear.
